// File: rtl/lbus_axis_pkg.sv
// lbus_axis_pkg: shared segment/beat types and helpers for the LBUS <-> AXIS converters.
package lbus_axis_pkg;
   localparam int NSEG     = 4;
   localparam int SEG_W    = 128;
   localparam int SEG_KEEP = 16;
   localparam int BEAT_W   = NSEG * (SEG_W + SEG_KEEP) + 2;

   typedef struct packed {
      logic [SEG_W-1:0]    data;
      logic [SEG_KEEP-1:0] keep;
      logic                eop;
      logic                err;
   } seg_t;

   typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

   function automatic logic [SEG_KEEP-1:0] mty2keep(input logic [3:0] mty);
      return {SEG_KEEP{1'b1}} << mty;
   endfunction
endpackage

// File: rtl/axis_beat_fifo.sv
// axis_beat_fifo: synchronous beat FIFO with occupancy count and registered first-word fall-through output.
module axis_beat_fifo
   import lbus_axis_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = BEAT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_wr,
   input  logic [W-1:0]           i_wdata,
   input  logic                   i_ready,
   output logic                   o_valid,
   output logic [W-1:0]           o_data,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_ld;

   // the output register counts as one of the DEPTH entries
   assign w_ld    = (r_cnt != '0) & (~o_valid | i_ready);
   assign o_count = r_cnt + CW'(o_valid);

   always_ff @(posedge clk)
      if (i_wr) r_mem[r_wp] <= i_wdata;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         r_wp    <= r_wp + AW'(i_wr);
         r_rp    <= r_rp + AW'(w_ld);
         r_cnt   <= r_cnt + CW'(i_wr) - CW'(w_ld);
         o_valid <= w_ld | (o_valid & ~i_ready);
         if (w_ld) o_data <= r_mem[r_rp];
      end
endmodule

// File: rtl/lbus2axis.sv
// lbus2axis: 4x128b LBUS RX to 512b AXI4-Stream; packs segments so each packet starts at tdata[511:384],
// buffers beats in a FIFO and truncates a packet cleanly when the FIFO overflows.
module lbus2axis
   import lbus_axis_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] rx_lbus_seg0_data,
   input  logic         rx_lbus_seg0_ena,
   input  logic         rx_lbus_seg0_sop,
   input  logic         rx_lbus_seg0_eop,
   input  logic [3:0]   rx_lbus_seg0_mty,
   input  logic         rx_lbus_seg0_err,
   input  logic [127:0] rx_lbus_seg1_data,
   input  logic         rx_lbus_seg1_ena,
   input  logic         rx_lbus_seg1_sop,
   input  logic         rx_lbus_seg1_eop,
   input  logic [3:0]   rx_lbus_seg1_mty,
   input  logic         rx_lbus_seg1_err,
   input  logic [127:0] rx_lbus_seg2_data,
   input  logic         rx_lbus_seg2_ena,
   input  logic         rx_lbus_seg2_sop,
   input  logic         rx_lbus_seg2_eop,
   input  logic [3:0]   rx_lbus_seg2_mty,
   input  logic         rx_lbus_seg2_err,
   input  logic [127:0] rx_lbus_seg3_data,
   input  logic         rx_lbus_seg3_ena,
   input  logic         rx_lbus_seg3_sop,
   input  logic         rx_lbus_seg3_eop,
   input  logic [3:0]   rx_lbus_seg3_mty,
   input  logic         rx_lbus_seg3_err,
   output logic [511:0] m_axis_tdata,
   output logic [63:0]  m_axis_tkeep,
   output logic         m_axis_tlast,
   output logic         m_axis_tuser,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         overflow,
   output logic         proto_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [NSEG-1:0][SEG_W-1:0] r_d;
   logic [NSEG-1:0][3:0]       r_mty;
   logic [NSEG-1:0]            r_ena, r_sop, r_eop, r_err;
   seg_t [NSEG-2:0]            r_pend;
   logic [1:0]                 r_n;
   state_t                     r_st, w_st;
   seg_t [NSEG-1:0]            w_acc, w_bacc;
   logic [2:0]                 w_n;
   logic                       w_close, w_blast, w_berr, w_perr;
   logic                       w_pop, w_full, w_trunc, w_ovf, w_kill, w_push;
   logic [NSEG*SEG_W-1:0]      w_tdata;
   logic [NSEG*SEG_KEEP-1:0]   w_tkeep;
   logic [CW-1:0]              w_cnt, w_cnt_ap;
   logic [BEAT_W-1:0]          w_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_d   <= '0;
         r_mty <= '0;
         r_ena <= '0;
         r_sop <= '0;
         r_eop <= '0;
         r_err <= '0;
      end else begin
         r_d   <= {rx_lbus_seg3_data, rx_lbus_seg2_data, rx_lbus_seg1_data, rx_lbus_seg0_data};
         r_mty <= {rx_lbus_seg3_mty, rx_lbus_seg2_mty, rx_lbus_seg1_mty, rx_lbus_seg0_mty};
         r_ena <= {rx_lbus_seg3_ena, rx_lbus_seg2_ena, rx_lbus_seg1_ena, rx_lbus_seg0_ena};
         r_sop <= {rx_lbus_seg3_sop, rx_lbus_seg2_sop, rx_lbus_seg1_sop, rx_lbus_seg0_sop};
         r_eop <= {rx_lbus_seg3_eop, rx_lbus_seg2_eop, rx_lbus_seg1_eop, rx_lbus_seg0_eop};
         r_err <= {rx_lbus_seg3_err, rx_lbus_seg2_err, rx_lbus_seg1_err, rx_lbus_seg0_err};
      end

   // framing FSM and packer walk the segments in order; at most one beat closes per cycle
   always_comb begin
      w_acc            = '0;
      w_acc[NSEG-2:0]  = r_pend;
      w_bacc           = '0;
      w_n              = {1'b0, r_n};
      w_st             = r_st;
      w_close          = 1'b0;
      w_perr           = 1'b0;
      for (int s = 0; s < NSEG; s++)
         if (r_ena[s]) begin
            if (w_st == DROP) w_st = r_eop[s] ? IDLE : DROP;
            else if (w_st == IDLE && !r_sop[s]) w_perr = 1'b1;
            else begin
               w_perr = w_perr | (w_st == IN_PKT && r_sop[s]);
               w_acc[w_n[1:0]] = '{r_d[s], r_eop[s] ? mty2keep(r_mty[s]) : {SEG_KEEP{1'b1}},
                                   r_eop[s], r_eop[s] & r_err[s]};
               w_n  = w_n + 3'd1;
               w_st = r_eop[s] ? IDLE : IN_PKT;
               if (r_eop[s] || w_n == 3'(NSEG)) begin
                  w_close = 1'b1;
                  w_bacc  = w_acc;
                  w_acc   = '0;
                  w_n     = '0;
               end
            end
         end
   end

   always_comb begin
      w_tdata = '0;
      w_tkeep = '0;
      w_blast = 1'b0;
      w_berr  = 1'b0;
      for (int s = 0; s < NSEG; s++) begin
         w_tdata[(NSEG-1-s)*SEG_W +: SEG_W]       = w_bacc[s].data;
         w_tkeep[(NSEG-1-s)*SEG_KEEP +: SEG_KEEP] = w_bacc[s].keep;
         w_blast = w_blast | w_bacc[s].eop;
         w_berr  = w_berr | w_bacc[s].err;
      end
   end

   // the last free entry is kept for a terminating beat, so a truncated packet always ends with tlast
   assign w_pop    = m_axis_tvalid & m_axis_tready;
   assign w_cnt_ap = w_cnt - CW'(w_pop);
   assign w_full   = w_cnt_ap == CW'(FIFO_DEPTH);
   assign w_trunc  = w_close & ~w_blast & (w_cnt_ap == CW'(FIFO_DEPTH - 1));
   assign w_ovf    = w_close & (w_full | w_trunc);
   assign w_push   = w_close & ~w_full;
   assign w_kill   = w_ovf & ~w_blast;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pend    <= '0;
         r_n       <= '0;
         r_st      <= IDLE;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         r_pend    <= w_kill ? '0 : w_acc[NSEG-2:0];
         r_n       <= w_kill ? 2'd0 : w_n[1:0];
         r_st      <= w_kill ? DROP : w_st;
         overflow  <= w_ovf;
         proto_err <= w_perr;
      end

   axis_beat_fifo #(.DEPTH(FIFO_DEPTH), .W(BEAT_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_push),
      .i_wdata ({w_tdata, w_tkeep, w_blast | w_trunc, w_berr | w_trunc}),
      .i_ready (m_axis_tready),
      .o_valid (m_axis_tvalid),
      .o_data  (w_q),
      .o_count (w_cnt)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_q;
endmodule
